// File: rtl/vga_pkg.sv
// Frame geometry, packet constants and loader state encoding shared by the
// VRAM loader and the display side.
package vga_pkg;

  localparam int unsigned H_LEN   = 200;
  localparam int unsigned V_LEN   = 150;
  localparam int unsigned PIX     = H_LEN * V_LEN;
  localparam int unsigned AW      = 15;
  localparam int unsigned NFRAMES = 10;
  localparam int unsigned TIMEOUT = 1000000;
  localparam logic [7:0]  HDR     = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    GET_IDX,
    GET_HI,
    GET_LO
  } state_t;

endpackage

// File: rtl/vram_pixel_loader_if.sv
// Byte-stream input and VRAM write-port bundle of the pixel loader.
// The master side is the loader itself.
interface vram_pixel_loader_if;
  import vga_pkg::*;

  logic [7:0]         rx_data;
  logic               rx_valid;
  logic [NFRAMES-1:0] we;
  logic [AW-1:0]      waddr;
  logic [11:0]        wdata;
  logic               busy;
  logic               done;
  logic               err;
  logic [3:0]         cur_frame;

  modport master (
    input  rx_data, rx_valid,
    output we, waddr, wdata, busy, done, err, cur_frame
  );

  modport slave (
    output rx_data, rx_valid,
    input  we, waddr, wdata, busy, done, err, cur_frame
  );

endinterface

// File: rtl/vram_pixel_loader_timeout.sv
// Inter-byte gap counter: cleared by clr, advanced by en, expire flags the
// cycle whose increment would bring the count to CYCLES-1.
module loader_timeout
  import vga_pkg::*;
#(
  parameter int unsigned CYCLES = TIMEOUT
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = $clog2(CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(CYCLES - 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  // A strobe in the limit cycle wins, so the abort lands CYCLES cycles after the last byte.
  assign expire = en && !clr && (cnt == LIMIT);

endmodule

// File: rtl/vram_pixel_loader.sv
// Parses HDR / frame-index / RGB444 pixel-pair packets from the UART byte
// stream and writes each pixel into the selected frame VRAM.
module vram_pixel_loader #(
  parameter int unsigned PIX     = vga_pkg::PIX,
  parameter int unsigned TIMEOUT = vga_pkg::TIMEOUT,
  parameter logic [7:0]  HDR     = vga_pkg::HDR
) (
  input logic               clk,
  input logic               rstn,
  vram_pixel_loader_if.master bus
);
  import vga_pkg::state_t;
  import vga_pkg::IDLE;
  import vga_pkg::GET_IDX;
  import vga_pkg::GET_HI;
  import vga_pkg::GET_LO;

  localparam int unsigned AW = vga_pkg::AW;
  localparam int unsigned NF = vga_pkg::NFRAMES;
  localparam logic [AW-1:0] LAST   = AW'(PIX - 1);
  localparam logic [7:0]    NF8    = 8'(NF);
  localparam logic [NF-1:0] WE_ONE = NF'(1);

  state_t        state, state_n;
  logic          latch_idx, latch_r, wr_issue, abort, tmo_expire;
  logic [AW-1:0] pix_cnt, waddr;
  logic [3:0]    red, cur_frame;
  logic [11:0]   wdata;
  logic          write_pending, busy, done, err;

  loader_timeout #(.CYCLES(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (bus.rx_valid),
    .en     (state != IDLE),
    .expire (tmo_expire)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_n   = state;
    latch_idx = 1'b0;
    latch_r   = 1'b0;
    wr_issue  = 1'b0;
    abort     = 1'b0;
    if (tmo_expire) begin
      state_n = IDLE;
      abort   = 1'b1;
    end else if (bus.rx_valid) begin
      case (state)
        IDLE:    if (bus.rx_data == HDR) state_n = GET_IDX;
        GET_IDX: begin
          if (bus.rx_data < NF8) begin
            latch_idx = 1'b1;
            state_n   = GET_HI;
          end else begin
            abort   = 1'b1;
            state_n = IDLE;
          end
        end
        GET_HI: begin
          if (bus.rx_data[7:4] == 4'h0) begin
            latch_r = 1'b1;
            state_n = GET_LO;
          end else begin
            abort   = 1'b1;
            state_n = IDLE;
          end
        end
        GET_LO: begin
          wr_issue = 1'b1;
          state_n  = (pix_cnt == LAST) ? IDLE : GET_HI;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_cnt       <= '0;
      red           <= '0;
      cur_frame     <= '0;
      waddr         <= '0;
      wdata         <= '0;
      write_pending <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      write_pending <= wr_issue;
      done          <= wr_issue && (pix_cnt == LAST);
      err           <= abort;
      busy          <= (state != IDLE);
      if (latch_idx) begin
        cur_frame <= bus.rx_data[3:0];
        pix_cnt   <= '0;
      end
      if (latch_r) red <= bus.rx_data[3:0];
      if (wr_issue) begin
        waddr <= pix_cnt;
        wdata <= {red, bus.rx_data};
        if (pix_cnt != LAST) pix_cnt <= pix_cnt + 1'b1;
      end
    end
  end

  assign bus.we        = write_pending ? (WE_ONE << cur_frame) : '0;
  assign bus.waddr     = waddr;
  assign bus.wdata     = wdata;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.err       = err;
  assign bus.cur_frame = cur_frame;

endmodule

// File: tb/tb_vram_pixel_loader.sv
// Directed bench for vram_pixel_loader with a shortened frame and timeout so
// complete packets and idle-gap aborts fit in a short run.
module tb_vram_pixel_loader;

  localparam int PIX_T = 40;
  localparam int TMO_T = 50;

  typedef struct {
    logic [9:0]  we;
    logic [14:0] addr;
    logic [11:0] data;
    logic        done;
    int          cyc;
  } wr_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  wr_t  wr_log[$];
  int   err_cnt = 0, err_cyc = -1;
  int   done_cnt = 0, done_cyc = -1;
  int   busy_fall_cyc = -1;
  logic busy_q = 1'b0;
  int   strobe_cyc = 0;

  vram_pixel_loader_if bus ();

  vram_pixel_loader #(.PIX(PIX_T), .TIMEOUT(TMO_T)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (bus.we != '0) begin
      wr_t w;
      w.we   = bus.we;
      w.addr = bus.waddr;
      w.data = bus.wdata;
      w.done = bus.done;
      w.cyc  = cyc;
      wr_log.push_back(w);
    end
    if (bus.err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy_q && !bus.busy) busy_fall_cyc = cyc;
    busy_q = bus.busy;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    strobe_cyc   = cyc;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_pixels(input int seed, input int count);
    for (int n = 0; n < count; n++) begin
      send_byte({4'h0, 4'((n + seed) % 16)});
      send_byte(8'(8'h5A + seed));
    end
  endtask

  task automatic check_frame(input int frame, input int seed, input int base);
    int avail;
    check("frame.count", 32'(wr_log.size() - base), 32'(PIX_T));
    avail = wr_log.size() - base;
    if (avail > PIX_T) avail = PIX_T;
    for (int n = 0; n < avail; n++) begin
      check("frame.we",   32'(wr_log[base+n].we),   32'(1 << frame));
      check("frame.addr", 32'(wr_log[base+n].addr), 32'(n));
      check("frame.data", 32'(wr_log[base+n].data),
            32'({4'((n + seed) % 16), 8'(8'h5A + seed)}));
      check("frame.done", 32'(wr_log[base+n].done), 32'(n == PIX_T - 1));
    end
  endtask

  initial begin
    int base, e0, s, s2;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    // Reset values while rstn is held low
    #12;
    check("rst.we",        32'(bus.we),        32'h0);
    check("rst.waddr",     32'(bus.waddr),     32'h0);
    check("rst.wdata",     32'(bus.wdata),     32'h0);
    check("rst.busy",      32'(bus.busy),      32'h0);
    check("rst.done",      32'(bus.done),      32'h0);
    check("rst.err",       32'(bus.err),       32'h0);
    check("rst.cur_frame", 32'(bus.cur_frame), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    idle(2);

    // Full frame into frame 3
    send_byte(8'hA5);
    send_byte(8'h03);
    idle(1);
    check("full.busy_hi", 32'(bus.busy), 32'h1);
    send_pixels(0, PIX_T);
    idle(4);
    check_frame(3, 0, 0);
    check("full.done_cnt",  32'(done_cnt),      32'd1);
    check("full.busy_fall", 32'(busy_fall_cyc), 32'(done_cyc + 1));
    check("full.err_cnt",   32'(err_cnt),       32'd0);
    check("full.cur_frame", 32'(bus.cur_frame), 32'd3);
    check("full.hold_addr", 32'(bus.waddr),     32'(PIX_T - 1));
    check("full.hold_data", 32'(bus.wdata),     32'h75A);

    // Out-of-range frame index
    base = wr_log.size();
    e0   = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h0A);
    s = strobe_cyc;
    idle(3);
    check("idx.err_cnt",   32'(err_cnt),       32'(e0 + 1));
    check("idx.err_cyc",   32'(err_cyc),       32'(s + 1));
    check("idx.busy",      32'(bus.busy),      32'h0);
    check("idx.cur_frame", 32'(bus.cur_frame), 32'd3);
    check("idx.no_write",  32'(wr_log.size()), 32'(base));

    // Bad hi byte after one good pixel, then a clean reload of frame 1
    base = wr_log.size();
    e0   = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h12);
    send_byte(8'h3F);
    s = strobe_cyc;
    idle(3);
    check("badhi.writes", 32'(wr_log.size()), 32'(base + 1));
    if (wr_log.size() > base) begin
      check("badhi.we",   32'(wr_log[base].we),   32'h002);
      check("badhi.addr", 32'(wr_log[base].addr), 32'h0);
      check("badhi.data", 32'(wr_log[base].data), 32'h012);
    end
    check("badhi.err_cnt", 32'(err_cnt),  32'(e0 + 1));
    check("badhi.err_cyc", 32'(err_cyc),  32'(s + 1));
    check("badhi.busy",    32'(bus.busy), 32'h0);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_pixels(5, PIX_T);
    idle(4);
    check_frame(1, 5, base + 1);

    // Idle-gap timeout, then a byte landing on the limit cycle
    base = wr_log.size();
    e0   = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h07);
    s = strobe_cyc;
    wait_until(s + TMO_T + 3);
    check("tmo.err_cnt",  32'(err_cnt),       32'(e0 + 1));
    check("tmo.err_cyc",  32'(err_cyc),       32'(s + TMO_T));
    check("tmo.no_write", 32'(wr_log.size()), 32'(base));
    check("tmo.busy",     32'(bus.busy),      32'h0);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h07);
    s = strobe_cyc;
    wait_until(s + TMO_T - 2);
    send_byte(8'h34);
    wait_until(s + TMO_T + 5);
    check("edge.err_cnt", 32'(err_cnt),       32'(e0 + 1));
    check("edge.writes",  32'(wr_log.size()), 32'(base + 1));
    if (wr_log.size() > base) begin
      check("edge.we",   32'(wr_log[base].we),   32'h004);
      check("edge.addr", 32'(wr_log[base].addr), 32'h0);
      check("edge.data", 32'(wr_log[base].data), 32'h734);
    end
    check("edge.busy", 32'(bus.busy), 32'h1);
    send_byte(8'hFF);
    s2 = strobe_cyc;
    idle(3);
    check("edge.abort_cnt", 32'(err_cnt), 32'(e0 + 2));
    check("edge.abort_cyc", 32'(err_cyc), 32'(s2 + 1));

    // Reset in the middle of a packet to frame 4
    base = wr_log.size();
    e0   = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h04);
    send_pixels(9, 20);
    idle(1);
    check("rstmid.writes", 32'(wr_log.size()), 32'(base + 20));
    rstn = 1'b0;
    #1;
    check("rstmid.we",        32'(bus.we),        32'h0);
    check("rstmid.waddr",     32'(bus.waddr),     32'h0);
    check("rstmid.wdata",     32'(bus.wdata),     32'h0);
    check("rstmid.busy",      32'(bus.busy),      32'h0);
    check("rstmid.cur_frame", 32'(bus.cur_frame), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    send_byte(8'h00);
    send_byte(8'h37);
    idle(3);
    check("rstmid.ignore_busy",  32'(bus.busy),      32'h0);
    check("rstmid.ignore_write", 32'(wr_log.size()), 32'(base + 20));
    check("rstmid.ignore_err",   32'(err_cnt),       32'(e0));
    send_byte(8'hA5);
    send_byte(8'h04);
    send_pixels(9, PIX_T);
    idle(4);
    check_frame(4, 9, base + 20);

    // Noise in IDLE, then one pixel to frame 0
    base = wr_log.size();
    e0   = err_cnt;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    idle(2);
    check("noise.busy", 32'(bus.busy), 32'h0);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h0C);
    send_byte(8'h3D);
    s = strobe_cyc;
    idle(3);
    check("noise.err_cnt", 32'(err_cnt),       32'(e0));
    check("noise.writes",  32'(wr_log.size()), 32'(base + 1));
    if (wr_log.size() > base) begin
      check("noise.we",      32'(wr_log[base].we),   32'h001);
      check("noise.addr",    32'(wr_log[base].addr), 32'h0);
      check("noise.data",    32'(wr_log[base].data), 32'hC3D);
      check("noise.latency", 32'(wr_log[base].cyc),  32'(s + 1));
      check("noise.done",    32'(wr_log[base].done), 32'h0);
    end
    wait_until(s + TMO_T + 4);
    check("noise.tmo_err",  32'(err_cnt),  32'(e0 + 1));
    check("noise.tmo_busy", 32'(bus.busy), 32'h0);
    check("total.done_cnt", 32'(done_cnt), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
